pipelined_qc_rotator: RTL and testbench

Fully pipelined circular shifter that rotates within a runtime-selected lifting size Z (1..MAXZ), not the fixed MAXZ field. It supports right or left rotation per beat, a valid/ready handshake with backpressure, and a sideband tag carried through the pipe. It sits between the QC-LDPC base-matrix sequencer and the check-node/parity datapath. One rotation per circulant per cycle at full throughput.

---
 rtl/pipelined_qc_rotator.sv | 133 +++++++++++++
 tb/tb_pipelined_qc_rotator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_qc_rotator.sv
// Pipelined circular shifter that rotates within a runtime lifting size z <= MAXZ.
// Stage 0 masks and duplicates the word, NL shift stages follow, and the outputs are registered.
module pipelined_qc_rotator #(
  parameter int unsigned MAXZ                  = 81,
  parameter int unsigned PIPE_STAGES_PER_CYCLE = 1,
  parameter int unsigned TAG_W                 = 8,
  localparam int unsigned SW                   = $clog2(MAXZ),
  localparam int unsigned ZW                   = $clog2(MAXZ + 1)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAXZ-1:0]  in_data,
  input  logic [ZW-1:0]    in_z,
  input  logic [SW-1:0]    in_shift,
  input  logic             in_dir,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAXZ-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  localparam int P  = int'(PIPE_STAGES_PER_CYCLE);
  localparam int NL = (int'(SW) + P - 1) / P;
  localparam int DW = 2 * int'(MAXZ);

  logic             vld_d [NL+1];
  logic             vld_q [NL+1];
  logic [DW-1:0]    dat_d [NL+1];
  logic [DW-1:0]    dat_q [NL+1];
  logic [SW-1:0]    amt_d [NL+1];
  logic [SW-1:0]    amt_q [NL+1];
  logic [ZW-1:0]    z_d   [NL+1];
  logic [ZW-1:0]    z_q   [NL+1];
  logic             err_d [NL+1];
  logic             err_q [NL+1];
  logic [TAG_W-1:0] tag_d [NL+1];
  logic [TAG_W-1:0] tag_q [NL+1];

  logic             out_valid_d, out_valid_q;
  logic [MAXZ-1:0]  out_data_d,  out_data_q;
  logic [TAG_W-1:0] out_tag_d,   out_tag_q;
  logic             out_err_d,   out_err_q;
  logic             adv;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

  always_comb begin : comb_next
    logic [MAXZ-1:0] masked;
    logic            legal;
    logic [DW-1:0]   tmp;

    legal = (in_z != '0) && (in_z <= ZW'(MAXZ)) && (ZW'(in_shift) < in_z);
    for (int i = 0; i < int'(MAXZ); i++) begin
      masked[i] = in_data[i] & (i < int'(in_z));
    end

    // Bubbles and illegal beats carry zeros so idle outputs stay clean.
    vld_d[0] = in_valid;
    dat_d[0] = '0;
    amt_d[0] = '0;
    z_d[0]   = '0;
    err_d[0] = 1'b0;
    tag_d[0] = '0;
    if (in_valid) begin
      z_d[0]   = in_z;
      tag_d[0] = in_tag;
      err_d[0] = !legal;
      if (legal) begin
        dat_d[0] = {{MAXZ{1'b0}}, masked} | ({{MAXZ{1'b0}}, masked} << in_z);
        // Left rotate by s is a right rotate by z - s.
        amt_d[0] = (in_dir && in_shift != '0) ? SW'(in_z - ZW'(in_shift)) : in_shift;
      end
    end

    for (int i = 1; i <= NL; i++) begin
      vld_d[i] = vld_q[i-1];
      amt_d[i] = amt_q[i-1];
      z_d[i]   = z_q[i-1];
      err_d[i] = err_q[i-1];
      tag_d[i] = tag_q[i-1];
      tmp      = dat_q[i-1];
      for (int k = 0; k < int'(SW); k++) begin
        if ((k / P) == (i - 1) && amt_q[i-1][k]) tmp = tmp >> (1 << k);
      end
      dat_d[i] = tmp;
    end

    out_valid_d = vld_q[NL];
    out_tag_d   = tag_q[NL];
    out_err_d   = err_q[NL];
    for (int j = 0; j < int'(MAXZ); j++) begin
      out_data_d[j] = dat_q[NL][j] & (j < int'(z_q[NL]));
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      for (int i = 0; i <= NL; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
        amt_q[i] <= '0;
        z_q[i]   <= '0;
        err_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i <= NL; i++) begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
        amt_q[i] <= amt_d[i];
        z_q[i]   <= z_d[i];
        err_q[i] <= err_d[i];
        tag_q[i] <= tag_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
    end
  end
endmodule

// File: tb/tb_pipelined_qc_rotator.sv
// Bench for pipelined_qc_rotator: scoreboard of expected beats, random stalls, reset flush,
// and a second instance with three mux levels per register.
module tb_pipelined_qc_rotator;
  localparam int MAXZ  = 81;
  localparam int TAG_W = 8;
  localparam int SW    = $clog2(MAXZ);
  localparam int ZW    = $clog2(MAXZ + 1);
  localparam int LAT   = 8;
  localparam int LAT3  = 4;

  typedef logic [MAXZ-1:0] word_t;
  typedef struct {
    word_t            data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic             CLK = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_dir, out_valid, out_ready, out_err;
  word_t            in_data, out_data;
  logic [ZW-1:0]    in_z;
  logic [SW-1:0]    in_shift;
  logic [TAG_W-1:0] in_tag, out_tag;

  logic             q_in_valid, q_in_ready, q_in_dir, q_out_valid, q_out_err;
  logic             q_out_ready;
  word_t            q_in_data, q_out_data;
  logic [ZW-1:0]    q_in_z;
  logic [SW-1:0]    q_in_shift;
  logic [TAG_W-1:0] q_in_tag, q_out_tag;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  bit   done;

  logic             held_v;
  word_t            held_d;
  logic [TAG_W-1:0] held_t;
  logic             held_e;

  always #5 CLK = ~CLK;

  pipelined_qc_rotator #(.MAXZ(MAXZ), .PIPE_STAGES_PER_CYCLE(1), .TAG_W(TAG_W)) u_dut (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_z(in_z), .in_shift(in_shift), .in_dir(in_dir), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_err(out_err)
  );

  pipelined_qc_rotator #(.MAXZ(MAXZ), .PIPE_STAGES_PER_CYCLE(3), .TAG_W(TAG_W)) u_dut3 (
    .CLK(CLK), .rst_n(rst_n), .in_valid(q_in_valid), .in_ready(q_in_ready),
    .in_data(q_in_data), .in_z(q_in_z), .in_shift(q_in_shift), .in_dir(q_in_dir),
    .in_tag(q_in_tag), .out_valid(q_out_valid), .out_ready(q_out_ready),
    .out_data(q_out_data), .out_tag(q_out_tag), .out_err(q_out_err)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", name, obs, exp);
    end
  endtask

  // Reference rotation written straight from the index formulas.
  task automatic ref_rot(input word_t d, input int z, input int s, input bit dir,
                         output word_t o, output bit err);
    err = !(z >= 1 && z <= MAXZ && s < z);
    o = '0;
    if (!err) begin
      for (int j = 0; j < z; j++) o[j] = dir ? d[(j - s + z) % z] : d[(j + s) % z];
    end
  endtask

  task automatic send(input int z, input int s, input bit dir, input word_t d,
                      input logic [TAG_W-1:0] tag, input word_t exp_d, input bit exp_e,
                      output int waits);
    exp_t e;
    bit   got;
    in_z = ZW'(z); in_shift = SW'(s); in_dir = dir; in_data = d; in_tag = tag;
    in_valid = 1'b1;
    waits = 0;
    got = 1'b0;
    while (!got && waits < 200) begin
      @(negedge CLK);
      got = in_ready;
      @(posedge CLK);
      #1;
      if (!got) waits++;
    end
    check("accept", got, 1);
    if (got) begin
      e.data = exp_d; e.tag = tag; e.err = exp_e;
      sb.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic sendm(input int z, input int s, input bit dir, input word_t d,
                       input logic [TAG_W-1:0] tag);
    word_t r;
    bit    e;
    int    w;
    ref_rot(d, z, s, dir, r, e);
    send(z, s, dir, d, tag, r, e, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Output monitor: pops on each transfer, checks hold stability and in_ready while stalled.
  always @(negedge CLK) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_d);
        check("hold_tag", out_tag, held_t);
        check("hold_err", out_err, held_e);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_tag", out_tag, mon_e.tag);
          check("out_err", out_err, mon_e.err);
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_t = out_tag;
      held_e = out_err;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int    w, n, bad;
    word_t x, r;
    bit    re;
    in_valid = 1'b0; in_data = '0; in_z = '0; in_shift = '0; in_dir = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    q_in_valid = 1'b0; q_in_data = '0; q_in_z = '0; q_in_shift = '0; q_in_dir = 1'b0;
    q_in_tag = '0; q_out_ready = 1'b1;
    done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    rst_n = 1'b1;
    @(negedge CLK);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_out_err", out_err, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge CLK);
    #1;

    // z = MAXZ right by 1: bit 0 lands on bit 80, latency checked on an empty pipe.
    send(81, 1, 1'b0, word_t'(1), 8'h11, word_t'(1) << 80, 1'b0, w);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("latency", n, LAT);
    drain();

    x = word_t'({$urandom, $urandom, $urandom});
    send(27, 5, 1'b0, '1, 8'h21, (word_t'(1) << 27) - word_t'(1), 1'b0, w);
    send(27, 5, 1'b0, word_t'(1) << 5, 8'h22, word_t'(1), 1'b0, w);
    check("full_rate_wait", w, 0);
    send(27, 5, 1'b1, word_t'(1), 8'h23, word_t'(1) << 5, 1'b0, w);
    check("full_rate_wait", w, 0);
    ref_rot(x, 27, 22, 1'b0, r, re);
    send(27, 5, 1'b1, x, 8'h24, r, 1'b0, w);
    sendm(27, 3, 1'b0, x, 8'h30);
    send(0, 0, 1'b0, x, 8'h31, '0, 1'b1, w);
    send(82, 0, 1'b0, x, 8'h32, '0, 1'b1, w);
    send(27, 27, 1'b1, x, 8'h33, '0, 1'b1, w);
    sendm(27, 4, 1'b1, x, 8'h34);
    send(40, 0, 1'b0, x, 8'h40, x & ((word_t'(1) << 40) - word_t'(1)), 1'b0, w);
    send(40, 0, 1'b1, x, 8'h41, x & ((word_t'(1) << 40) - word_t'(1)), 1'b0, w);
    send(1, 0, 1'b0, '1, 8'h50, word_t'(1), 1'b0, w);
    send(1, 0, 1'b1, '1, 8'h51, word_t'(1), 1'b0, w);
    drain();

    // Random stream under random backpressure.
    fork
      begin
        for (int b = 0; b < 20; b++) begin
          int z, s;
          z = int'($urandom_range(1, MAXZ));
          s = int'($urandom_range(0, z - 1));
          if ($urandom_range(0, 7) == 0) s = z;
          sendm(z, s, 1'($urandom_range(0, 1)),
                word_t'({$urandom, $urandom, $urandom}), TAG_W'(8'h60 + b));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'b0;
          repeat ($urandom_range(1, 5)) @(posedge CLK);
          #1;
          out_ready = 1'b1;
          repeat ($urandom_range(1, 3)) @(posedge CLK);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with five beats in flight: nothing may emerge afterwards.
    for (int b = 0; b < 5; b++) begin
      sendm(27, b, 1'b0, word_t'({$urandom, $urandom, $urandom}), TAG_W'(8'h90 + b));
    end
    rst_n = 1'b0;
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, 0);
    check("flush_out_tag", out_tag, 0);
    check("flush_out_err", out_err, 0);
    bad = 0;
    repeat (12) begin
      @(posedge CLK);
      #1;
      if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 || out_err !== 1'b0) bad++;
    end
    check("flush_quiet", bad, 0);
    sendm(81, 80, 1'b1, word_t'({$urandom, $urandom, $urandom}), 8'hA0);
    drain();

    // Three mux levels per register: LAT = 4.
    q_in_data = word_t'(1); q_in_z = ZW'(27); q_in_shift = SW'(5); q_in_dir = 1'b1;
    q_in_tag = 8'h77; q_in_valid = 1'b1;
    @(negedge CLK);
    check("p3_in_ready", q_in_ready, 1);
    @(posedge CLK);
    #1;
    q_in_valid = 1'b0;
    n = 0;
    while (!q_out_valid && n < 30) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("p3_latency", n, LAT3);
    check("p3_data", q_out_data, word_t'(1) << 5);
    check("p3_tag", q_out_tag, 8'h77);
    check("p3_err", q_out_err, 0);
    q_in_data = '1; q_in_z = ZW'(1); q_in_shift = '0; q_in_dir = 1'b0; q_in_tag = 8'h78;
    q_in_valid = 1'b1;
    @(posedge CLK);
    #1;
    q_in_valid = 1'b0;
    n = 0;
    while (!q_out_valid && n < 30) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("p3_z1_data", q_out_data, word_t'(1));
    check("p3_z1_tag", q_out_tag, 8'h78);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
